slowclk_monitor: RTL and testbench



---
 rtl/slowclk_monitor_pkg.sv | 26 ++
 rtl/slowclk_monitor_edge_sync.sv | 57 +++++
 rtl/slowclk_monitor.sv | 141 ++++++++++++++
 tb/tb_slowclk_monitor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/slowclk_monitor_pkg.sv
// slowclk_monitor_pkg: state encoding, default parameters and helpers for slowclk_monitor.
// Revision: 1.0
`default_nettype none

package slowclk_monitor_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_TIMEOUT     = 200;
  localparam int DEF_LOCK_CNT    = 4;
  localparam int DEF_TOL         = 1;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  function automatic int unsigned abs_int(input int x);
    abs_int = (x < 0) ? -x : x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/slowclk_monitor_edge_sync.sv
// slowclk_monitor_edge_sync: edge_sync sub-block; synchroniser, optional glitch filter
// (GLITCH_FILTER_EN) and registered rise/fall strobes. Revision: 1.0
`default_nettype none

module slowclk_monitor_edge_sync
  import slowclk_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   sync_out;
  logic                   hist;
  logic                   take;

  assign sync_out = chain[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], async_in};
  end

`ifdef GLITCH_FILTER_EN
  // A new level is taken only once sync_out has held it for three cycles.
  logic [1:0] dly;

  always_ff @(posedge clk) begin
    if (rst) dly <= '0;
    else     dly <= {dly[0], sync_out};
  end

  assign take = (sync_out != hist) && (dly[0] == sync_out) && (dly[1] == sync_out);
`else
  assign take = sync_out ^ hist;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      if (take) hist <= sync_out;
      rise <= take & sync_out;
      fall <= take & ~sync_out;
    end
  end

endmodule

`default_nettype wire

// File: rtl/slowclk_monitor.sv
// slowclk_monitor: edge strobes, half-period measurement and lock/loss tracking of a slow
// clock in the fastclk domain. Optional macro GLITCH_FILTER_EN. Revision: 1.0
`default_nettype none

module slowclk_monitor
  import slowclk_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int LOCK_CNT    = DEF_LOCK_CNT,
  parameter int TOL         = DEF_TOL
) (
  input  logic             fastclk,
  input  logic             rst,
  input  logic             slowclk_i,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] half_period_o,
  output logic             meas_valid_o,
  output logic             locked_o,
  output logic             lost_o
);

  localparam int                 MATCH_W     = $clog2(LOCK_CNT + 1);
  localparam logic [MATCH_W-1:0] LOCK_TARGET = MATCH_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]   HC_MAX      = '1;
  localparam logic [CNT_W-1:0]   HC_TIMEOUT  = CNT_W'(TIMEOUT);
  localparam int unsigned        TOL_U       = TOL;

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    hc;
  logic [CNT_W-1:0]    prev;
  logic                prev_valid;
  logic                prev_valid_next;
  logic [MATCH_W-1:0]  match;
  logic [MATCH_W-1:0]  match_next;
  logic                meas_take;
  logic                edge_det;
  logic                in_tol;
  logic signed [CNT_W:0] diff;

  slowclk_monitor_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk      (fastclk),
    .rst      (rst),
    .async_in (slowclk_i),
    .rise     (rise_o),
    .fall     (fall_o)
  );

  assign edge_det = rise_o | fall_o;
  // One extra bit keeps the signed difference of two unsigned counts from wrapping.
  assign diff     = $signed({1'b0, hc}) - $signed({1'b0, prev});
  assign in_tol   = abs_int(int'(diff)) <= TOL_U;

  always_ff @(posedge fastclk) begin
    if (rst) state <= ACQUIRE;
    else     state <= state_next;
  end

  always_comb begin
    state_next      = state;
    match_next      = match;
    prev_valid_next = prev_valid;
    meas_take       = 1'b0;
    case (state)
      ACQUIRE: begin
        if (edge_det) begin
          state_next      = LOCKING;
          match_next      = '0;
          prev_valid_next = 1'b0;
        end
      end
      LOCKING: begin
        if (edge_det) begin
          meas_take       = 1'b1;
          prev_valid_next = 1'b1;
          if (prev_valid && in_tol) begin
            match_next = match + 1'b1;
            if (match_next == LOCK_TARGET) state_next = LOCKED;
          end else begin
            match_next = '0;
          end
        end else if (hc >= HC_TIMEOUT) begin
          state_next = LOST;
        end
      end
      LOCKED: begin
        if (edge_det) begin
          meas_take       = 1'b1;
          prev_valid_next = 1'b1;
          if (!in_tol) begin
            state_next = LOCKING;
            match_next = '0;
          end
        end else if (hc >= HC_TIMEOUT) begin
          state_next = LOST;
        end
      end
      LOST: begin
        if (edge_det) begin
          state_next      = LOCKING;
          match_next      = '0;
          prev_valid_next = 1'b0;
        end
      end
      default: state_next = ACQUIRE;
    endcase
  end

  always_ff @(posedge fastclk) begin
    if (rst) begin
      hc            <= '0;
      prev          <= '0;
      prev_valid    <= 1'b0;
      match         <= '0;
      half_period_o <= '0;
      meas_valid_o  <= 1'b0;
      locked_o      <= 1'b0;
      lost_o        <= 1'b0;
    end else begin
      if (edge_det)          hc <= CNT_W'(1);
      else if (hc != HC_MAX) hc <= hc + 1'b1;
      match        <= match_next;
      prev_valid   <= prev_valid_next;
      meas_valid_o <= meas_take;
      if (meas_take) begin
        half_period_o <= hc;
        prev          <= hc;
      end
      locked_o <= (state_next == LOCKED);
      lost_o   <= (state_next == LOST);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_slowclk_monitor.sv
// tb_slowclk_monitor: directed vector table plus hand sequences for slowclk_monitor.
// Revision: 1.0
`default_nettype none

module tb_slowclk_monitor;
  import slowclk_monitor_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 8;
  localparam int TIMEOUT     = 200;
  localparam int LOCK_CNT    = 4;
  localparam int TOL         = 1;
`ifdef GLITCH_FILTER_EN
  localparam int LAT       = SYNC_STAGES + 2;
  localparam int PULSE_EXP = 0;
`else
  localparam int LAT       = SYNC_STAGES;
  localparam int PULSE_EXP = 2;
`endif

  logic             fastclk = 1'b0;
  logic             rst = 1'b1;
  logic             slowclk_i = 1'b0;
  logic             rise_o, fall_o, meas_valid_o, locked_o, lost_o;
  logic [CNT_W-1:0] half_period_o;

  slowclk_monitor #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT),
    .LOCK_CNT    (LOCK_CNT),
    .TOL         (TOL)
  ) dut (
    .fastclk       (fastclk),
    .rst           (rst),
    .slowclk_i     (slowclk_i),
    .rise_o        (rise_o),
    .fall_o        (fall_o),
    .half_period_o (half_period_o),
    .meas_valid_o  (meas_valid_o),
    .locked_o      (locked_o),
    .lost_o        (lost_o)
  );

  always #5 fastclk = ~fastclk;

  int cyc = 0;
  always @(posedge fastclk) cyc <= cyc + 1;

  int rise_cnt = 0, fall_cnt = 0, meas_cnt = 0, lost_rises = 0;
  int last_edge_cyc = 0, first_rise_cyc = -1, lost_rise_cyc = 0;
  logic lost_d = 1'b0;

  always @(negedge fastclk) begin
    if (rise_o) begin
      rise_cnt++;
      last_edge_cyc = cyc;
      if (first_rise_cyc < 0) first_rise_cyc = cyc;
    end
    if (fall_o) begin
      fall_cnt++;
      last_edge_cyc = cyc;
    end
    if (meas_valid_o) meas_cnt++;
    if (lost_o && !lost_d) begin
      lost_rises++;
      lost_rise_cyc = cyc;
    end
    lost_d = lost_o;
  end

  int tests = 0, fails = 0, drive_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge fastclk);
    #1;
  endtask

  task automatic toggle();
    @(posedge fastclk);
    #1;
    slowclk_i = ~slowclk_i;
    drive_cyc = cyc;
  endtask

  task automatic toggle_hold(input int hold);
    toggle();
    wait_cyc(hold - 1);
  endtask

  typedef struct {
    int hold;
    int exp_half;
    bit exp_locked;
  } vec_t;

  vec_t vt[20];

  initial begin
    int m0, lr0, s0, k;

    // hold = cycles until next toggle; expected values reflect this toggle's edge
    vt[0]  = '{64, 64, 1'b0};  vt[1]  = '{64, 64, 1'b0};
    vt[2]  = '{64, 64, 1'b0};  vt[3]  = '{64, 64, 1'b0};
    vt[4]  = '{64, 64, 1'b1};  vt[5]  = '{70, 64, 1'b1};
    vt[6]  = '{64, 70, 1'b0};  vt[7]  = '{64, 64, 1'b0};
    vt[8]  = '{64, 64, 1'b0};  vt[9]  = '{64, 64, 1'b0};
    vt[10] = '{64, 64, 1'b0};  vt[11] = '{65, 64, 1'b1};
    vt[12] = '{64, 65, 1'b1};  vt[13] = '{66, 64, 1'b1};
    vt[14] = '{64, 66, 1'b0};  vt[15] = '{64, 64, 1'b0};
    vt[16] = '{64, 64, 1'b0};  vt[17] = '{64, 64, 1'b0};
    vt[18] = '{64, 64, 1'b0};  vt[19] = '{64, 64, 1'b1};

    wait_cyc(3);
    check("rst_half", 32'(half_period_o), 0);
    check("rst_flags", {rise_o, fall_o, meas_valid_o, locked_o, lost_o}, 0);
    check("rst_state", dut.state, ACQUIRE);
    rst = 1'b0;

    wait_cyc(500);
    check("idle_strobes", rise_cnt + fall_cnt, 0);
    check("idle_state", dut.state, ACQUIRE);
    check("idle_lock_lost", {locked_o, lost_o}, 0);

    // edge 1: latency, single-cycle strobe, no measurement
    toggle_hold(64);
    check("rise_latency", first_rise_cyc - drive_cyc, 1 + LAT);
    check("rise_once", rise_cnt, 1);
    check("e1_meas", meas_cnt, 0);
    check("e1_state", dut.state, LOCKING);

    for (int i = 0; i < 20; i++) begin
      toggle_hold(vt[i].hold);
      check($sformatf("v%0d_half", i), 32'(half_period_o), vt[i].exp_half);
      check($sformatf("v%0d_locked", i), 32'(locked_o), 32'(vt[i].exp_locked));
      check($sformatf("v%0d_lost", i), 32'(lost_o), 0);
    end
    check("table_meas", meas_cnt, 20);
    check("table_rises", rise_cnt, 11);
    check("table_falls", fall_cnt, 10);

    // stuck high: lost exactly TIMEOUT cycles after the edge is consumed
    k = 0;
    while (!lost_o && k < 400) begin
      @(negedge fastclk);
      k++;
    end
    #1;
    check("lost_seen", 32'(lost_o), 1);
    check("lost_delay", lost_rise_cyc - last_edge_cyc, TIMEOUT + 1);
    check("lost_state", dut.state, LOST);
    check("lost_unlocked", 32'(locked_o), 0);
    check("lost_half_hold", 32'(half_period_o), 64);

    m0 = meas_cnt;
    toggle();
    wait_cyc(10);
    check("recover_lost", 32'(lost_o), 0);
    check("recover_state", dut.state, LOCKING);
    check("recover_nomeas", meas_cnt, m0);

    // edge coincides with hc reaching TIMEOUT: measured, not lost
    wait_cyc(189);
    lr0 = lost_rises;
    toggle();
    wait_cyc(20);
    check("tmo_edge_half", 32'(half_period_o), TIMEOUT);
    check("tmo_edge_meas", meas_cnt, m0 + 1);
    check("tmo_edge_nolost", lost_rises, lr0);

    // one cycle longer: LOST for one cycle, then edge recovers
    wait_cyc(180);
    toggle();
    wait_cyc(20);
    check("tmo_plus1_lost", lost_rises, lr0 + 1);
    check("tmo_plus1_state", dut.state, LOCKING);
    check("tmo_plus1_half", 32'(half_period_o), TIMEOUT);
    check("tmo_plus1_meas", meas_cnt, m0 + 1);

    wait_cyc(43);
    for (int i = 0; i < 5; i++) toggle_hold(64);
    check("relock", 32'(locked_o), 1);
    check("relock_half", 32'(half_period_o), 64);

    @(posedge fastclk);
    #1 rst = 1'b1;
    wait_cyc(1);
    check("midrst_half", 32'(half_period_o), 0);
    check("midrst_flags", {rise_o, fall_o, meas_valid_o, locked_o, lost_o}, 0);
    check("midrst_state", dut.state, ACQUIRE);
    rst = 1'b0;

    wait_cyc(20);
    s0 = rise_cnt + fall_cnt;
    toggle();
    wait_cyc(1);
    toggle();
    wait_cyc(20);
    check("pulse2_strobes", rise_cnt + fall_cnt - s0, PULSE_EXP);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
